// File: rtl/imem_boot_loader.sv
// imem_boot_loader
//   Boot-time loader for the fetch-stage instruction memory. Accepts a
//   length-prefixed, XOR-checksummed byte stream (LEN_LO, LEN_HI, 4*N data
//   bytes LSB first, checksum). It writes each assembled 32-bit word to the
//   instruction memory and holds the core in reset until the image is verified.
//
// Ports
//   clk, rst                      clock; asynchronous active-low reset
//   start                         pulse: begin/restart a load (IDLE/RUN/ERROR only)
//   rx_valid, rx_data, rx_ready   byte stream handshake (transfer = valid && ready)
//   imem_write_en/addr/data       one-cycle word write port to instruction memory
//   core_rst                      high everywhere except RUN
//   core_run, done                high only in RUN
//   err                           high only in ERROR
module imem_boot_loader #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_write_en,
    output logic [ADDR_W-1:0] imem_write_addr,
    output logic [31:0]       imem_write_data,
    output logic              core_rst,
    output logic              core_run,
    output logic              done,
    output logic              err
);
    typedef enum logic [2:0] {
        S_IDLE, S_LEN0, S_LEN1, S_DATA, S_WRITE, S_CSUM, S_RUN, S_ERROR
    } state_t;

    state_t          state, state_nx;
    logic [ADDR_W:0] widx;      // one spare bit so N = DEPTH ends without wrap
    logic [1:0]      bcnt;      // byte lane within the current word
    logic [15:0]     nwords;
    logic [7:0]      csum;
    logic [23:0]     part;      // lower three bytes of the word in progress
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]     wr_data;

    logic            xfer;
    logic            enter_load;
    logic [15:0]     len_in;
    logic            len_ok;
    logic [ADDR_W:0] widx_inc;
    logic            last_word;

    assign xfer       = rx_valid && rx_ready;
    assign enter_load = start && (state == S_IDLE || state == S_RUN || state == S_ERROR);
    assign len_in     = {rx_data, nwords[7:0]};
    assign len_ok     = (len_in != 16'd0) && (32'(len_in) <= DEPTH);
    assign widx_inc   = widx + 1'b1;
    assign last_word  = (32'(widx_inc) == 32'(nwords));

    // Address/data are captured with the 4th byte so they hold between writes.
    assign imem_write_addr = wr_addr;
    assign imem_write_data = wr_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    // Next state and state-decoded outputs; rx_ready depends only on state,
    // so no input reaches an output combinationally.
    always_comb begin
        state_nx      = state;
        rx_ready      = 1'b0;
        imem_write_en = 1'b0;
        core_rst      = 1'b1;
        core_run      = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        case (state)
            S_IDLE:  if (start) state_nx = S_LEN0;
            S_LEN0: begin
                rx_ready = 1'b1;
                if (xfer) state_nx = S_LEN1;
            end
            S_LEN1: begin
                rx_ready = 1'b1;
                if (xfer) state_nx = len_ok ? S_DATA : S_ERROR;
            end
            S_DATA: begin
                rx_ready = 1'b1;
                if (xfer && bcnt == 2'd3) state_nx = S_WRITE;
            end
            S_WRITE: begin
                imem_write_en = 1'b1;
                state_nx      = last_word ? S_CSUM : S_DATA;
            end
            S_CSUM: begin
                rx_ready = 1'b1;
                if (xfer) state_nx = (rx_data == csum) ? S_RUN : S_ERROR;
            end
            S_RUN: begin
                core_rst = 1'b0;
                core_run = 1'b1;
                done     = 1'b1;
                if (start) state_nx = S_LEN0;
            end
            S_ERROR: begin
                err = 1'b1;
                if (start) state_nx = S_LEN0;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            widx    <= '0;
            bcnt    <= '0;
            nwords  <= '0;
            csum    <= '0;
            part    <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            if (enter_load) begin
                widx <= '0;
                bcnt <= '0;
                csum <= '0;
            end
            // Checksum covers LEN_LO through the last data byte.
            if (xfer && state != S_CSUM) csum <= csum ^ rx_data;
            case (state)
                S_LEN0: if (xfer) nwords[7:0]  <= rx_data;
                S_LEN1: if (xfer) nwords[15:8] <= rx_data;
                S_DATA: if (xfer) begin
                    bcnt <= bcnt + 2'd1;
                    case (bcnt)
                        2'd0: part[7:0]   <= rx_data;
                        2'd1: part[15:8]  <= rx_data;
                        2'd2: part[23:16] <= rx_data;
                        default: begin
                            wr_data <= {rx_data, part};
                            wr_addr <= widx[ADDR_W-1:0];
                        end
                    endcase
                end
                S_WRITE: widx <= widx_inc;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_boot_loader.sv
`timescale 1ns/1ps
module tb_imem_boot_loader;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_ready;
    logic              imem_write_en;
    logic [ADDR_W-1:0] imem_write_addr;
    logic [31:0]       imem_write_data;
    logic              core_rst, core_run, done, err;

    imem_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
        .imem_write_en(imem_write_en), .imem_write_addr(imem_write_addr),
        .imem_write_data(imem_write_data),
        .core_rst(core_rst), .core_run(core_run), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit in_stream = 0;
    int start_glitch_idx = -1;

    logic [7:0]        stim[$];
    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];

    typedef struct {
        int n;
        bit bad_csum;
        int gap;
        bit exp_done;
        bit exp_err;
    } vec_t;
    vec_t tbl[8];

    task automatic check1(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Write capture and, under a continuous stream, ready must drop only in write cycles.
    always @(negedge clk) begin
        if (imem_write_en) begin
            wa.push_back(imem_write_addr);
            wd.push_back(imem_write_data);
        end
        if (in_stream && rx_valid) begin
            checks++;
            if (rx_ready === imem_write_en) begin
                errors++;
                $display("FAIL ready_vs_write ready %0b write_en %0b", rx_ready, imem_write_en);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int  t;
        bit  acc;
        t = 0;
        acc = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!acc && t < 50) begin
            @(negedge clk);
            acc = rx_ready;
            @(posedge clk);
            #1;
            t++;
        end
        rx_valid = 1'b0;
        if (!acc) check1("byte_accept_timeout", 64'(acc), 64'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic build_stream(input int n, input bit bad);
        logic [7:0] x;
        stim.delete();
        stim.push_back(8'(n));
        stim.push_back(8'(n >> 8));
        if (n >= 1 && n <= DEPTH) begin
            for (int i = 0; i < 4 * n; i++) stim.push_back(8'($urandom));
            x = 8'h00;
            foreach (stim[i]) x = x ^ stim[i];
            stim.push_back(x ^ (bad ? 8'h5a : 8'h00));
        end
    endtask

    // Reference: words come straight from the byte list, in order, from address 0.
    task automatic model_writes();
        int n;
        n = int'({stim[1], stim[0]});
        if (!(n >= 1 && n <= DEPTH) || stim.size() < 4 * n + 3) n = 0;
        check1("write_count", 64'(wa.size()), 64'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check1("write_addr", 64'(wa[i]), 64'(i));
            check1("write_data", 64'(wd[i]),
                   64'({stim[4*i+5], stim[4*i+4], stim[4*i+3], stim[4*i+2]}));
        end
    endtask

    task automatic run_load(input int gap, input bit exp_done, input bit exp_err, input bit do_start);
        int k;
        wa.delete();
        wd.delete();
        if (do_start) pulse_start();
        in_stream = (gap == 0);
        foreach (stim[i]) begin
            if (gap > 0) begin
                rx_data = 8'($urandom);
                k = $urandom_range(0, gap);
                repeat (k) begin @(posedge clk); #1; end
            end
            if (i == start_glitch_idx) start = 1'b1;
            send_byte(stim[i]);
            start = 1'b0;
        end
        in_stream = 0;
        @(negedge clk);
        check1("done_after_last", 64'(done), 64'(exp_done));
        check1("err_after_last", 64'(err), 64'(exp_err));
        check1("core_rst_after_last", 64'(core_rst), 64'(!exp_done));
        check1("core_run_after_last", 64'(core_run), 64'(exp_done));
        @(posedge clk);
        #1;
        model_writes();
    endtask

    task automatic example_stream(input logic [7:0] cs);
        logic [7:0] ex[11];
        ex = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h92};
        ex[10] = cs;
        stim.delete();
        foreach (ex[i]) stim.push_back(ex[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n: 1,     bad_csum: 0, gap: 0, exp_done: 1, exp_err: 0};
        tbl[1] = '{n: 3,     bad_csum: 0, gap: 2, exp_done: 1, exp_err: 0};
        tbl[2] = '{n: 5,     bad_csum: 1, gap: 2, exp_done: 0, exp_err: 1};
        tbl[3] = '{n: 0,     bad_csum: 0, gap: 0, exp_done: 0, exp_err: 1};
        tbl[4] = '{n: 1025,  bad_csum: 0, gap: 1, exp_done: 0, exp_err: 1};
        tbl[5] = '{n: 16,    bad_csum: 0, gap: 3, exp_done: 1, exp_err: 0};
        tbl[6] = '{n: 2,     bad_csum: 1, gap: 0, exp_done: 0, exp_err: 1};
        tbl[7] = '{n: DEPTH, bad_csum: 0, gap: 0, exp_done: 1, exp_err: 0};

        // Reset values while rst is held low.
        #12;
        check1("reset_outputs",
               64'({rx_ready, imem_write_en, imem_write_addr, imem_write_data, core_rst, core_run, done, err}),
               64'({1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        check1("idle_not_ready", 64'(rx_ready), 64'd0);

        // Reference image: two known words, then RUN.
        example_stream(8'h92);
        run_load(0, 1, 0, 1);
        check1("ex_writes", 64'(wa.size()), 64'd2);
        if (wa.size() >= 2) begin
            check1("ex_addr0", 64'(wa[0]), 64'd0);
            check1("ex_data0", 64'(wd[0]), 64'h0000_0013);
            check1("ex_addr1", 64'(wa[1]), 64'd1);
            check1("ex_data1", 64'(wd[1]), 64'h0010_0093);
        end
        // Address/data hold the last write after it.
        check1("addr_hold", 64'(imem_write_addr), 64'd1);
        check1("data_hold", 64'(imem_write_data), 64'h0010_0093);

        // Bad checksum, then recovery.
        example_stream(8'h93);
        run_load(0, 0, 1, 1);
        example_stream(8'h92);
        run_load(1, 1, 0, 1);

        // Table-driven random images.
        foreach (tbl[i]) begin
            build_stream(tbl[i].n, tbl[i].bad_csum);
            run_load(tbl[i].gap, tbl[i].exp_done, tbl[i].exp_err, 1);
            if (tbl[i].n == DEPTH && wa.size() == DEPTH)
                check1("last_addr", 64'(wa[DEPTH-1]), 64'(DEPTH - 1));
        end

        // Reset after the 6th byte: that byte completes a word, yet no write appears.
        example_stream(8'h92);
        wa.delete();
        wd.delete();
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(stim[i]);
        rst = 1'b0;
        #1;
        check1("midreset_outputs",
               64'({rx_ready, imem_write_en, imem_write_addr, imem_write_data, core_rst, core_run, done, err}),
               64'({1'b0, 1'b0, 10'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        repeat (3) @(posedge clk);
        #1;
        check1("midreset_no_write", 64'(wa.size()), 64'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run_load(0, 1, 0, 1);

        // Start during DATA is ignored.
        build_stream(4, 0);
        start_glitch_idx = 5;
        run_load(0, 1, 0, 1);
        start_glitch_idx = -1;

        // Start in RUN: core held next cycle, reload from LEN0 without another start.
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check1("rerun_core_rst", 64'(core_rst), 64'd1);
        check1("rerun_done", 64'(done), 64'd0);
        check1("rerun_core_run", 64'(core_run), 64'd0);
        check1("rerun_ready", 64'(rx_ready), 64'd1);
        @(posedge clk);
        #1;
        build_stream(3, 0);
        run_load(2, 1, 0, 0);

        // Start in ERROR clears err.
        build_stream(0, 0);
        run_load(0, 0, 1, 1);
        pulse_start();
        @(negedge clk);
        check1("err_cleared", 64'(err), 64'd0);
        @(posedge clk);
        #1;
        build_stream(2, 0);
        run_load(0, 1, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
